bg_pattern_gen: RTL and testbench
=================================

// Module: bg_pattern_gen
// PURPOSE
//  Parametrised VGA background generator. Sits on the background layer of the
//  VGA mux and supplies per-pixel colour plus a bracket-hit flag.
//  Adds selectable modes over a plain static fill: solid, scrolling checkerboard,
//  and checkerboard with a flashing outer border. All are frame-synchronous.
//  Output is pipelined to 2 cycles after pixelX/pixelY.
// PARAMETERS
//  X_SIZE          640    visible width in pixels (x = 0..X_SIZE-1)
//  Y_SIZE          480    visible height in pixels (y = 0..Y_SIZE-1)
//  BRACKET_OFFSET  10     inset of inner bracket lines from frame edge
//  TILE_LOG2       5      checker tile edge = 2**TILE_LOG2 pixels
//  SCROLL_STEP     2      pixels added to scrollX per frame when scrollEn=1
//  FLASH_FRAMES    30     frames per flash half-period (>=1)
//  BG_COLOR        8'h58  solid fill, and tile colour A
//  TILE_B_COLOR    8'h4C  tile colour B
//  BORDER_COLOR    8'hFC  outer border colour (yellow)
//  BRACKET_COLOR   8'hFF  inner bracket colour (white)
// PORTS
//  clk              in   1   pixel clock
//  resetN           in   1   asynchronous active-low reset
//  startOfFrame     in   1   one-cycle pulse at the start of each frame
//  pixelX           in   11  current pixel column
//  pixelY           in   11  current pixel row
//  mode             in   2   0 solid, 1 checker, 2 checker+flash, 3 = treated as 0
//  scrollEn         in   1   enable horizontal checker scroll
//  BG_RGB           out  8   RRRGGGBB colour, 2-cycle latency
//  boardersDrawReq  out  1   1 when the pixel is on an inner bracket line; aligned with BG_RGB
//  frameCount       out  8   frames seen since reset, wraps 255->0
// BEHAVIOUR
//  Reset: asynchronous and active-low. While resetN=0:
//   BG_RGB=8'h00, boardersDrawReq=0, frameCount=0.
//   modeLatched=0, scrollX=0, flashCnt=0, flashPhase=0, both pipeline stages cleared.
//  Frame-rate state updates only in a cycle where startOfFrame=1:
//   modeLatched<=mode. A mode change mid-frame has no effect until the next pulse.
//   frameCount<=frameCount+1, mod 256.
//   If scrollEn=1: scrollX<=(scrollX+SCROLL_STEP) mod 2**(TILE_LOG2+1).
//   If scrollEn=0: scrollX holds.
//   If the new latched mode is 2: flashCnt increments. When it reaches FLASH_FRAMES-1,
//    flashCnt goes to 0 and flashPhase toggles.
//   If the new latched mode is not 2: flashCnt=0 and flashPhase=0.
//  New frame state applies to pixels sampled in the cycle after the pulse.
//   The pixel sampled in the pulse cycle uses the old state.
//  Stage 1 (registered):
//   inFrame = x<X_SIZE && y<Y_SIZE.
//   outer   = x==0 || y==0 || x==X_SIZE-1 || y==Y_SIZE-1.
//   bracket = x==BRACKET_OFFSET || y==BRACKET_OFFSET
//             || x==X_SIZE-1-BRACKET_OFFSET || y==Y_SIZE-1-BRACKET_OFFSET.
//   tile    = bit TILE_LOG2 of (x+scrollX) XOR bit TILE_LOG2 of y.
//   The x+scrollX sum is 12 bits wide, with no truncation before bit select.
//  Stage 2 (registered, drives outputs), priority top-down:
//   1. !inFrame: BG_RGB=8'h00, drawReq=0.
//   2. bracket: BRACKET_COLOR, drawReq=1.
//   3. outer: BORDER_COLOR; but in mode 2 with flashPhase=1, use the stage-2 fill instead.
//   4. fill: mode 1/2 -> tile ? TILE_B_COLOR : BG_COLOR; mode 0/3 -> BG_COLOR.
//   drawReq=0 except for case 2.
//  Modes 0 and 3 are identical. scrollX still advances in mode 0 but is invisible.
//  Reset asserted mid-frame clears everything immediately. The first valid output
//   appears 2 cycles after reset is released; a mode other than 0 needs a startOfFrame first.
// TESTING
//  T1 reset: resetN=0 with random pixels -> BG_RGB=00, drawReq=0, frameCount=0;
//     release, pixel (100,100) -> 2 cycles later 8'h58.
//  T2 priority: mode 0, pixels (10,0),(0,5),(629,240),(700,10) -> FF/1, FC/0, FF/1, 00/0,
//     each 2 cycles after its input.
//  T3 checker: mode=1 + startOfFrame; (0,40) -> 4C; (32,40) -> 58; (31,31) -> 58.
//  T4 scroll: scrollEn=1, 32 frames -> scrollX=0 (64 wrap);
//     after 16 frames (scrollX=32) pixel (0,40) -> 58.
//  T5 flash: mode=2, run 30 frames -> (0,200) shows the fill colour;
//     60 frames -> FC; switch to mode 1 -> phase=0, border FC.
//  T6 mid-frame mode change: mode 0->1 between pulses -> no colour change until the
//     cycle after the next startOfFrame; frameCount 255->0 on wrap.

Source files
------------

// File: rtl/bg_pattern_gen.sv
// VGA background layer: solid, scrolling checkerboard, or checkerboard with flashing border.
// Per-pixel colour and bracket-hit flag appear two cycles after pixelX/pixelY.
module bg_pattern_gen #(
   parameter int unsigned X_SIZE         = 640,
   parameter int unsigned Y_SIZE         = 480,
   parameter int unsigned BRACKET_OFFSET = 10,
   parameter int unsigned TILE_LOG2      = 5,
   parameter int unsigned SCROLL_STEP    = 2,
   parameter int unsigned FLASH_FRAMES   = 30,
   parameter logic [7:0]  BG_COLOR       = 8'h58,
   parameter logic [7:0]  TILE_B_COLOR   = 8'h4C,
   parameter logic [7:0]  BORDER_COLOR   = 8'hFC,
   parameter logic [7:0]  BRACKET_COLOR  = 8'hFF
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [1:0]  mode,
   input  logic        scrollEn,
   output logic [7:0]  BG_RGB,
   output logic        boardersDrawReq,
   output logic [7:0]  frameCount
);

   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_FLASH = 2'd2,
      MODE_ALT   = 2'd3
   } mode_e;

   localparam int unsigned SW = TILE_LOG2 + 1;
   localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   localparam logic [10:0]   X_LIM      = 11'(X_SIZE);
   localparam logic [10:0]   Y_LIM      = 11'(Y_SIZE);
   localparam logic [10:0]   X_LAST     = 11'(X_SIZE - 1);
   localparam logic [10:0]   Y_LAST     = 11'(Y_SIZE - 1);
   localparam logic [10:0]   BR_LO      = 11'(BRACKET_OFFSET);
   localparam logic [10:0]   BR_XHI     = 11'(X_SIZE - 1 - BRACKET_OFFSET);
   localparam logic [10:0]   BR_YHI     = 11'(Y_SIZE - 1 - BRACKET_OFFSET);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
   localparam logic [SW-1:0] STEP       = SW'(SCROLL_STEP);

   // Frame-rate state
   mode_e         mode_q, mode_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [SW-1:0] scroll_x_q, scroll_x_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic          flash_phase_q, flash_phase_d;

   // Stage 1
   logic          in_frame_q, in_frame_d;
   logic          outer_q, outer_d;
   logic          bracket_q, bracket_d;
   logic          tile_q, tile_d;
   mode_e         s1_mode_q;
   logic          s1_phase_q;
   logic [11:0]   x_sum;

   // Stage 2
   logic [7:0]    rgb_q, rgb_d;
   logic          req_q, req_d;

   always_comb begin
      mode_d        = mode_q;
      frame_cnt_d   = frame_cnt_q;
      scroll_x_d    = scroll_x_q;
      flash_cnt_d   = flash_cnt_q;
      flash_phase_d = flash_phase_q;
      if (startOfFrame) begin
         mode_d      = mode_e'(mode);
         frame_cnt_d = frame_cnt_q + 8'd1;
         if (scrollEn)
            scroll_x_d = scroll_x_q + STEP;
         if (mode_d == MODE_FLASH) begin
            if (flash_cnt_q == FLASH_LAST) begin
               flash_cnt_d   = '0;
               flash_phase_d = ~flash_phase_q;
            end else begin
               flash_cnt_d = flash_cnt_q + FW'(1);
            end
         end else begin
            flash_cnt_d   = '0;
            flash_phase_d = 1'b0;
         end
      end
   end

   // Mode and flash phase travel with the pixel so a pulse never splits one pixel's view of state
   always_comb begin
      x_sum      = {1'b0, pixelX} + 12'(scroll_x_q);
      in_frame_d = (pixelX < X_LIM) && (pixelY < Y_LIM);
      outer_d    = (pixelX == '0) || (pixelY == '0) || (pixelX == X_LAST) || (pixelY == Y_LAST);
      bracket_d  = (pixelX == BR_LO) || (pixelY == BR_LO) ||
                   (pixelX == BR_XHI) || (pixelY == BR_YHI);
      tile_d     = x_sum[TILE_LOG2] ^ pixelY[TILE_LOG2];
   end

   always_comb begin
      rgb_d = BG_COLOR;
      req_d = 1'b0;
      if ((s1_mode_q == MODE_CHECK) || (s1_mode_q == MODE_FLASH))
         rgb_d = tile_q ? TILE_B_COLOR : BG_COLOR;
      if (!in_frame_q) begin
         rgb_d = '0;
      end else if (bracket_q) begin
         rgb_d = BRACKET_COLOR;
         req_d = 1'b1;
      end else if (outer_q && !((s1_mode_q == MODE_FLASH) && s1_phase_q)) begin
         rgb_d = BORDER_COLOR;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mode_q        <= MODE_SOLID;
         frame_cnt_q   <= '0;
         scroll_x_q    <= '0;
         flash_cnt_q   <= '0;
         flash_phase_q <= 1'b0;
         in_frame_q    <= 1'b0;
         outer_q       <= 1'b0;
         bracket_q     <= 1'b0;
         tile_q        <= 1'b0;
         s1_mode_q     <= MODE_SOLID;
         s1_phase_q    <= 1'b0;
         rgb_q         <= '0;
         req_q         <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         frame_cnt_q   <= frame_cnt_d;
         scroll_x_q    <= scroll_x_d;
         flash_cnt_q   <= flash_cnt_d;
         flash_phase_q <= flash_phase_d;
         in_frame_q    <= in_frame_d;
         outer_q       <= outer_d;
         bracket_q     <= bracket_d;
         tile_q        <= tile_d;
         s1_mode_q     <= mode_q;
         s1_phase_q    <= flash_phase_q;
         rgb_q         <= rgb_d;
         req_q         <= req_d;
      end
   end

   assign BG_RGB          = rgb_q;
   assign boardersDrawReq = req_q;
   assign frameCount      = frame_cnt_q;

endmodule

// File: tb/tb_bg_pattern_gen.sv
// Scoreboard bench for bg_pattern_gen: expected pixels queued on drive, compared two edges later.
module tb_bg_pattern_gen;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic [1:0]  mode;
   logic        scrollEn;
   logic [7:0]  BG_RGB;
   logic        boardersDrawReq;
   logic [7:0]  frameCount;

   always #5 clk = ~clk;

   bg_pattern_gen #(
      .X_SIZE(640), .Y_SIZE(480), .BRACKET_OFFSET(10), .TILE_LOG2(5),
      .SCROLL_STEP(2), .FLASH_FRAMES(30)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY), .mode(mode), .scrollEn(scrollEn),
      .BG_RGB(BG_RGB), .boardersDrawReq(boardersDrawReq), .frameCount(frameCount)
   );

   typedef struct packed {
      logic       vld;
      logic [7:0] rgb;
      logic       req;
   } exp_t;

   exp_t sb[$];

   int unsigned m_mode, m_scroll, m_cnt, m_phase, m_frames;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic exp_t model_pix(input int x, input int y);
      exp_t e;
      int   m;
      bit   in_f, outer, br, tile;
      m     = (m_mode == 3) ? 0 : int'(m_mode);
      in_f  = (x < 640) && (y < 480);
      outer = (x == 0) || (y == 0) || (x == 639) || (y == 479);
      br    = (x == 10) || (y == 10) || (x == 629) || (y == 469);
      tile  = bit'((((x + int'(m_scroll)) >> 5) & 1) ^ ((y >> 5) & 1));
      e.vld = 1'b1;
      e.req = 1'b0;
      if (!in_f)                                e.rgb = 8'h00;
      else if (br)                              begin e.rgb = 8'hFF; e.req = 1'b1; end
      else if (outer && !(m == 2 && m_phase == 1)) e.rgb = 8'hFC;
      else if (m == 1 || m == 2)                e.rgb = tile ? 8'h4C : 8'h58;
      else                                      e.rgb = 8'h58;
      return e;
   endfunction

   // Called at a negedge; returns at the following negedge.
   task automatic step(input int x, input int y, input bit sof, input bit vld, input string tag);
      exp_t e;
      pixelX       = 11'(x);
      pixelY       = 11'(y);
      startOfFrame = sof;
      e            = model_pix(x, y);
      e.vld        = vld && resetN;
      sb.push_back(e);
      @(posedge clk);
      if (sof && resetN) begin
         m_mode   = mode;
         m_frames = (m_frames + 1) % 256;
         if (scrollEn) m_scroll = (m_scroll + 2) % 64;
         if (m_mode == 2) begin
            if (m_cnt == 29) begin m_cnt = 0; m_phase ^= 1; end
            else m_cnt++;
         end else begin
            m_cnt = 0; m_phase = 0;
         end
      end
      @(negedge clk);
      startOfFrame = 1'b0;
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         if (e.vld) begin
            check_val({tag, " rgb"}, BG_RGB, e.rgb);
            check_val({tag, " req"}, boardersDrawReq, e.req);
         end
      end
      check_val({tag, " frames"}, frameCount, m_frames);
   endtask

   task automatic apply_reset();
      resetN = 1'b0;
      #1;
      check_val("rst async rgb", BG_RGB, 0);
      check_val("rst async req", boardersDrawReq, 0);
      check_val("rst async frames", frameCount, 0);
      m_mode = 0; m_scroll = 0; m_cnt = 0; m_phase = 0; m_frames = 0;
      sb.delete();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         step($urandom_range(700, 0), $urandom_range(520, 0), 1'($urandom_range(1, 0)), 1'b0, "rst");
         check_val("rst rgb", BG_RGB, 0);
         check_val("rst req", boardersDrawReq, 0);
      end
      resetN = 1'b1;
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      pixelX       = '0;
      pixelY       = '0;
      mode         = 2'd0;
      scrollEn     = 1'b0;
      @(negedge clk);
      apply_reset();

      // T1 / T2: first pixel after reset, then priority in mode 0
      step(100, 100, 0, 1, "t1");
      step(10, 0, 0, 1, "t2a");
      step(0, 5, 0, 1, "t2b");
      step(629, 240, 0, 1, "t2c");
      step(700, 10, 0, 1, "t2d");

      // T3: checkerboard
      mode = 2'd1;
      step(5, 5, 1, 1, "t3 pulse");
      step(0, 40, 0, 1, "t3a");
      step(1, 40, 0, 1, "t3b");
      step(32, 40, 0, 1, "t3c");
      step(31, 31, 0, 1, "t3d");

      // T4: scroll 16 frames then 16 more (wraps at 64)
      scrollEn = 1'b1;
      for (int i = 0; i < 16; i++) step(1, 40, 1, 1, "t4 run");
      step(1, 40, 0, 1, "t4 half");
      step(0, 40, 0, 1, "t4 edge");
      for (int i = 0; i < 16; i++) step(1, 40, 1, 1, "t4 run");
      step(1, 40, 0, 1, "t4 wrap");
      scrollEn = 1'b0;

      // T5: flash border
      mode = 2'd2;
      for (int i = 0; i < 30; i++) step(0, 200, 1, 1, "t5 run");
      step(0, 200, 0, 1, "t5 phase1");
      for (int i = 0; i < 30; i++) step(0, 200, 1, 1, "t5 run");
      step(0, 200, 0, 1, "t5 phase0");
      for (int i = 0; i < 30; i++) step(0, 200, 1, 1, "t5 run");
      mode = 2'd1;
      step(0, 200, 1, 1, "t5 switch");
      step(0, 200, 0, 1, "t5 mode1");

      // T6: mid-frame mode change, then frame counter wrap
      mode = 2'd0;
      step(40, 40, 0, 1, "t6 hold");
      step(1, 40, 0, 1, "t6 hold");
      step(1, 40, 1, 1, "t6 pulse");
      step(1, 40, 0, 1, "t6 after");
      mode = 2'd3;
      for (int i = 0; i < 260; i++) step(1, 40, 1, 1, "t6 wrap");

      // Reset in the middle of a frame
      mode = 2'd2;
      step(1, 40, 1, 1, "mid");
      step(300, 300, 0, 1, "mid");
      apply_reset();
      step(100, 100, 0, 1, "post rst");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         mode     = 2'($urandom_range(3, 0));
         scrollEn = 1'($urandom_range(1, 0));
         step($urandom_range(700, 0), $urandom_range(520, 0),
              ($urandom_range(7, 0) == 0), 1, "rand");
      end

      step(0, 0, 0, 0, "flush");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
